// File: rtl/pixel_unpacker.sv
// pixel_unpacker: serialises tri-exposure 128-bit words into aligned RGB565 pixels
module pixel_unpacker #(
  parameter int PIX_W        = 16,
  parameter int WORD_W       = 128,
  parameter int FRAME_PIXELS = 307200
)(
  input  logic              clk_25M,
  input  logic              rst_25M,
  input  logic [WORD_W-1:0] pixel_data_high,
  input  logic [WORD_W-1:0] pixel_data_mid,
  input  logic [WORD_W-1:0] pixel_data_low,
  input  logic              pixel_data_valid,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [PIX_W-1:0]  pixel_high,
  output logic [PIX_W-1:0]  pixel_mid,
  output logic [PIX_W-1:0]  pixel_low,
  output logic              pixel_valid,
  output logic              eof,
  output logic              underflow,
  output logic              overflow
);
  localparam int PPW = WORD_W / PIX_W;
  localparam int IW = PPW > 1 ? $clog2(PPW) : 1;
  localparam int CW = FRAME_PIXELS > 1 ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(PPW - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_PIXELS - 1);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;
  logic [3*WORD_W-1:0] r_cur, r_nxt;
  logic [3*WORD_W-1:0] w_in;
  logic                w_serve, w_pop;
  assign w_in    = {pixel_data_high, pixel_data_mid, pixel_data_low};
  assign w_serve = pix_req && r_state != EMPTY;
  assign w_pop   = w_serve && r_idx == IDX_LAST;
  // shared two-slot store, pixel serialiser, frame counter and sticky flags
  always_ff @(posedge clk_25M) begin
    if (rst_25M) begin
      r_state     <= EMPTY;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_cur       <= '0;
      r_nxt       <= '0;
      pixel_high  <= '0;
      pixel_mid   <= '0;
      pixel_low   <= '0;
      pixel_valid <= 1'b0;
      eof         <= 1'b0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
    end else if (frame_start) begin
      r_state     <= EMPTY;
      r_idx       <= '0;
      r_cnt       <= '0;
      pixel_valid <= 1'b0;
      eof         <= 1'b0;
    end else begin
      pixel_valid <= w_serve;
      eof         <= w_serve && r_cnt == CNT_LAST;
      if (w_serve) begin
        pixel_high <= r_cur[2*WORD_W + r_idx*PIX_W +: PIX_W];
        pixel_mid  <= r_cur[WORD_W + r_idx*PIX_W +: PIX_W];
        pixel_low  <= r_cur[r_idx*PIX_W +: PIX_W];
        r_idx      <= w_pop ? '0 : r_idx + 1'b1;
        r_cnt      <= r_cnt == CNT_LAST ? '0 : r_cnt + 1'b1;
      end else if (pix_req) begin
        pixel_high <= '0;
        pixel_mid  <= '0;
        pixel_low  <= '0;
        underflow  <= 1'b1;
      end
      case (r_state)
        EMPTY: if (pixel_data_valid) begin
          r_cur   <= w_in;
          r_state <= ONE;
        end
        ONE: if (w_pop) begin
          if (pixel_data_valid) r_cur <= w_in;
          else r_state <= EMPTY;
        end else if (pixel_data_valid) begin
          r_nxt   <= w_in;
          r_state <= TWO;
        end
        TWO: if (w_pop) begin
          r_cur <= r_nxt;
          if (pixel_data_valid) r_nxt <= w_in;
          else r_state <= ONE;
        end else if (pixel_data_valid) overflow <= 1'b1;
        default: r_state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker: scoreboard bench for pixel_unpacker with a 16-pixel frame
module tb_pixel_unpacker;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] d_h = '0, d_m = '0, d_l = '0;
  logic         d_v = 1'b0, fs = 1'b0, req = 1'b0;
  logic [15:0]  p_h, p_m, p_l;
  logic         p_v, eof, uf, of;
  typedef struct packed {logic [15:0] h; logic [15:0] m; logic [15:0] l; logic e;} exp_t;
  exp_t        q[$];
  logic [15:0] m_words[$];
  int          m_idx = 0, m_cnt = 0, total = 0, bad = 0, n = 0;
  logic        m_uf = 1'b0, m_of = 1'b0;

  pixel_unpacker #(.FRAME_PIXELS(16)) dut (
    .clk_25M(clk), .rst_25M(rst),
    .pixel_data_high(d_h), .pixel_data_mid(d_m), .pixel_data_low(d_l),
    .pixel_data_valid(d_v), .frame_start(fs), .pix_req(req),
    .pixel_high(p_h), .pixel_mid(p_m), .pixel_low(p_l),
    .pixel_valid(p_v), .eof(eof), .underflow(uf), .overflow(of)
  );

  always #20 clk = ~clk;

  function automatic logic [127:0] mk(input logic [15:0] b, input logic [15:0] off);
    logic [127:0] w;
    for (int k = 0; k < 8; k++) w[k*16 +: 16] = b + off + 16'(k);
    return w;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endfunction

  task automatic step(input logic v, input logic [15:0] b, input logic r, input logic f, input logic rs);
    exp_t e;
    logic popped;
    int   sz;
    d_h = mk(b, 16'h0000); d_m = mk(b, 16'h1111); d_l = mk(b, 16'h2222);
    d_v = v; req = r; fs = f; rst = rs;
    if (rs) begin
      m_words.delete(); m_idx = 0; m_cnt = 0; m_uf = 1'b0; m_of = 1'b0;
    end else if (f) begin
      m_words.delete(); m_idx = 0; m_cnt = 0;
    end else begin
      popped = 1'b0;
      sz = m_words.size();
      if (r) begin
        if (sz > 0) begin
          e.h = m_words[0] + 16'(m_idx);
          e.m = e.h + 16'h1111;
          e.l = e.h + 16'h2222;
          e.e = (m_cnt == 15);
          q.push_back(e);
          m_cnt = e.e ? 0 : m_cnt + 1;
          if (m_idx == 7) begin
            void'(m_words.pop_front());
            popped = 1'b1;
            m_idx = 0;
          end else m_idx++;
        end else m_uf = 1'b1;
      end
      if (v) begin
        if (sz == 2 && !popped) m_of = 1'b1;
        else m_words.push_back(b);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flags(input string nm);
    chk({nm, "_uf"}, 32'(uf), 32'(m_uf));
    chk({nm, "_of"}, 32'(of), 32'(m_of));
    chk({nm, "_q"}, 32'(q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (p_v === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pixel act=%h exp=none", p_h);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pix_h", 32'(p_h), 32'(e.h));
        chk("pix_m", 32'(p_m), 32'(e.m));
        chk("pix_l", 32'(p_l), 32'(e.l));
        chk("eof", 32'(eof), 32'(e.e));
      end
    end
  end

  initial begin
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_pix", {p_h, p_l}, 32'h0);
    chk("rst_ctl", {28'h0, p_v, eof, uf, of}, 32'h0);
    idle(1);
    // single word, eight consecutive pixels
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      chk("w1_first", 32'(p_h), 32'(k));
    end
    idle(1);
    flags("w1");
    chk("w1_noflags", {30'h0, uf, of}, 32'h0);
    // request with nothing stored
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("uf_valid", 32'(p_v), 32'd0);
    chk("uf_pix", {p_h, p_m}, 32'h0);
    chk("uf_flag", 32'(uf), 32'd1);
    step(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    flags("uf_idx");
    // overflow: third word dropped
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
    chk("of_flag", 32'(of), 32'd1);
    for (int k = 0; k < 16; k++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("of17_valid", 32'(p_v), 32'd0);
    chk("of17_uf", 32'(uf), 32'd1);
    idle(1);
    flags("of");
    // streaming with refill on the pop cycle, 16-pixel frames
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    n = 0;
    for (int w = 1; w <= 4; w++)
      for (int k = 0; k < 8; k++) begin
        step(k == 7 && w < 4, 16'(16'h0100 + 16'(16 * w)), 1'b1, 1'b0, 1'b0);
        chk("stream_valid", 32'(p_v), 32'd1);
        chk("stream_eof", 32'(eof), 32'(n % 16 == 15));
        n++;
      end
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("idle_valid", 32'(p_v), 32'd0);
    chk("idle_hold", 32'(p_h), 32'h0137);
    flags("stream");
    chk("stream_noflags", {30'h0, uf, of}, 32'h0);
    // frame_start at idx 3 with both slots full
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0050, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0060, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0070, 1'b1, 1'b1, 1'b0);
    chk("fs_valid", 32'(p_v), 32'd0);
    chk("fs_of_kept", 32'(of), 32'd1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("fs_empty_valid", 32'(p_v), 32'd0);
    chk("fs_empty_uf", 32'(uf), 32'd1);
    step(1'b1, 16'h0080, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    flags("fs");
    // reset at idx 3 with both slots full
    step(1'b1, 16'h0090, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00a0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h00b0, 1'b1, 1'b0, 1'b1);
    chk("mrst_pix", {p_h, p_m}, 32'h0);
    chk("mrst_pixl", 32'(p_l), 32'h0);
    chk("mrst_ctl", {28'h0, p_v, eof, uf, of}, 32'h0);
    idle(1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("mrst_empty_valid", 32'(p_v), 32'd0);
    chk("mrst_empty_uf", 32'(uf), 32'd1);
    idle(2);
    flags("end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pixel_unpacker.md
Name: pixel_unpacker

Overview:
- Sits directly downstream of the tri-exposure pixel buffer, in the clk_25M domain.
- Accepts 128-bit words for the high, mid and low exposures, all on one shared valid strobe.
- Serialises each word into 8 RGB565 pixels, one pixel per display request, and presents aligned high/mid/low pixels to the HDR merge stage.
- Provides a 2-word skid store per exposure, underflow/overflow flags and frame pixel counting.

Parameters:
- PIX_W, 16, bits per pixel (RGB565).
- WORD_W, 128, input word width; PIXELS_PER_WORD = WORD_W/PIX_W = 8.
- FRAME_PIXELS, 307200, pixels per frame (640x480); sets the eof pulse position.

Ports:
- clk_25M  input  1  pixel clock; all logic is synchronous to its rising edge.
- rst_25M  input  1  synchronous, active-high reset.
- pixel_data_high  input  128  high-exposure word.
- pixel_data_mid  input  128  mid-exposure word.
- pixel_data_low  input  128  low-exposure word.
- pixel_data_valid  input  1  one-cycle strobe; all three words are valid this cycle.
- frame_start  input  1  one-cycle pulse from display timing before the first active pixel; flushes the block.
- pix_req  input  1  display requests one pixel this cycle.
- pixel_high  output  16  high-exposure pixel.
- pixel_mid  output  16  mid-exposure pixel.
- pixel_low  output  16  low-exposure pixel.
- pixel_valid  output  1  outputs hold a real pixel.
- eof  output  1  one-cycle pulse with the last pixel of a frame.
- underflow  output  1  sticky; a pix_req arrived while no word was stored.
- overflow  output  1  sticky; a word arrived while both slots were full.

Behaviour:
- Reset values, while rst_25M=1 (synchronous):
  - pixel_high/mid/low=0, pixel_valid=0, eof=0, underflow=0, overflow=0.
  - Store state EMPTY, pixel index=0, frame pixel counter=0.
- Store structure:
  - Three parallel 2-entry slots (CUR, NXT), one per exposure.
  - All three always move together, so one shared state machine controls them.
- States and transitions:
  - EMPTY: valid -> load CUR, go ONE.
  - ONE: valid without a pop -> load NXT, go TWO. Pop without valid -> EMPTY. Pop and valid together -> load CUR, stay ONE.
  - TWO: pop -> NXT moves to CUR, go ONE. If valid arrives in the same cycle as the pop, the new word goes to NXT and the state stays TWO. Valid without a pop -> word dropped, overflow set, state unchanged.
- Serving a request:
  - pix_req in ONE or TWO serves the request.
  - Outputs register CUR[idx*16 +: 16] for each exposure; pixel 0 is bits [15:0], pixel 7 is bits [127:112].
  - pixel_valid=1 the next cycle, so latency is 1 cycle from pix_req.
  - idx increments by 1.
- Pop: a pop occurs when a request is served with idx==7; idx then wraps to 0.
- Underflow:
  - pix_req in EMPTY -> pixel outputs 0, pixel_valid=0 next cycle, underflow set.
  - idx and the frame counter do not advance.
- Idle cycles: with no pix_req, pixel_valid=0 the next cycle and the pixel outputs hold their last value.
- Frame counter and eof:
  - The counter increments on every served pixel.
  - When a served pixel is number FRAME_PIXELS-1: eof=1 aligned with that pixel's pixel_valid, and the counter wraps to 0.
- frame_start:
  - Acts like reset for the store state, idx and frame counter, and clears pixel_valid.
  - It does not clear the underflow/overflow flags.
  - It has priority over a simultaneous pixel_data_valid (that word is discarded) and over pix_req (no pixel served).
- Flag clearing: underflow and overflow clear only on rst_25M.
- Reset priority: rst_25M overrides everything, including mid-word and mid-frame; no partial pixel is emitted after reset.

Test Plan:
- Load one word high=0x0007_0006_0005_0004_0003_0002_0001_0000 (mid/low = high+0x1111 per lane); hold pix_req 8 cycles -> pixel_high 0x0000..0x0007 on consecutive cycles, each 1 cycle after its request; pixel_mid 0x1111..0x1118; state returns to EMPTY; no flags.
- Send 3 valid strobes with no pix_req -> first two words stored, third dropped, overflow=1; then 16 requests -> exactly words 1 and 2 emitted in order, and a 17th request sets underflow.
- Stream words every 8 cycles while pix_req is held, with valid coinciding with the idx==7 pop -> continuous pixel_valid, no gap, no flags.
- pix_req with nothing stored -> pixel_valid=0, outputs 0, underflow=1, idx unchanged.
- FRAME_PIXELS=16 override: serve 16 pixels -> eof high only with pixel 15; the counter wraps and the next eof comes 16 pixels later.
- Assert frame_start, then rst_25M, each at idx=3 with the state in TWO -> after frame_start: EMPTY, idx=0, flags kept; after reset: all outputs and flags 0.
